mod_n_cascade_counter: RTL

- Parametrised synchronous successor to the lab's mod-10 ripple counter.
- Holds DIGITS cascaded modulo-MODULUS digits (decimal by default) with up/down count, enable, synchronous parallel load, terminal-count output for chaining, and a wrap pulse plus sticky overflow flag.
- Used as the counting core for display, timer and stopwatch lab designs; all digits switch on the same clk edge, so there is no ripple skew.

---
 rtl/mod_n_cascade_counter.sv | 58 +++++
 1 files changed

// File: rtl/mod_n_cascade_counter.sv
// mod_n_cascade_counter: synchronous cascade of modulo-MODULUS digits with up/down count, load, terminal count, wrap pulse and sticky overflow.
module mod_n_cascade_counter #(
  parameter int MODULUS = 10,
  parameter int WIDTH = 4,
  parameter int DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [DIGITS*WIDTH-1:0] load_val,
  input  logic                    ovf_clr,
  output logic [DIGITS*WIDTH-1:0] q,
  output logic                    tc,
  output logic                    wrap,
  output logic                    ovf
);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);
  logic [DIGITS-1:0]       at_top, at_zero, step;
  logic [DIGITS*WIDTH-1:0] q_next;
  genvar i;
  for (i = 0; i < DIGITS; i++) begin : g_dig
    logic [WIDTH-1:0] d, l;
    logic             bad, lbad;
    assign d          = q[i*WIDTH +: WIDTH];
    assign l          = load_val[i*WIDTH +: WIDTH];
    assign bad        = {1'b0, d} >= MOD_W;
    assign lbad       = {1'b0, l} >= MOD_W;
    assign at_top[i]  = d == TOP;
    assign at_zero[i] = d == '0;
    // out-of-range digits self-heal to 0 on any non-load edge
    assign q_next[i*WIDTH +: WIDTH] = load     ? (lbad ? '0 : l) :
                                      bad      ? '0 :
                                      !step[i] ? d :
                                      up       ? (at_top[i] ? '0 : d + 1'b1) :
                                                 (at_zero[i] ? TOP : d - 1'b1);
  end
  always_comb begin
    step    = '0;
    step[0] = en;
    for (int k = 1; k < DIGITS; k++)
      step[k] = step[k-1] & (up ? at_top[k-1] : at_zero[k-1]);
  end
  assign tc = en & (up ? &at_top : &at_zero);
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= ~load & tc;
      ovf  <= (~load & tc) | (ovf & ~ovf_clr);
    end
  end
endmodule
